wb_mem_responder: RTL
=====================

# wb_mem_responder

Pipelined Wishbone B4 slave backed by a single-port word-organised RAM. It answers the instruction-fetch and data-memory masters in simulation and FPGA builds. It accepts up to `FIFO_DEPTH` outstanding requests, completes each one after a fixed `LATENCY`, and applies back-pressure through `wb_stall_o`. It is the responder side of the stb/cyc/ack/stall handshake that the core's masters drive.

## Interface
- `ADDR_WIDTH`, default 10: word-address width; memory holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 1: cycles from request acceptance to `wb_ack_o`. Legal range is 1..4.
- `FIFO_DEPTH`, default 2: maximum outstanding (accepted, not yet acked) requests. Legal range is 1..4.
- `clk_i`  in  1: single clock, all state on rising edge.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `wb_adr_i`  in  32: byte address.
- `wb_dat_i`  in  32: write data.
- `wb_dat_o`  out  32: read data, valid when `wb_ack_o`=1.
- `wb_we_i`  in  1: 1 = write, 0 = read.
- `wb_sel_i`  in  4: byte-lane enables; bit n covers bits [8n+7:8n].
- `wb_stb_i`  in  1: request strobe.
- `wb_cyc_i`  in  1: bus cycle active.
- `wb_ack_o`  out  1: one-cycle completion pulse per accepted request.
- `wb_stall_o`  out  1: responder cannot accept a request this cycle.

## Operation
- **Accept:** a request is accepted in a cycle where `wb_cyc_i & wb_stb_i & !wb_stall_o` is true.
- **Address:** word index = `wb_adr_i[ADDR_WIDTH+1:2]`.
  - Bits [1:0] are ignored.
  - Bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo 2^ADDR_WIDTH words.
- **Write:** committed at the accept edge. Only lanes with `wb_sel_i`=1 are updated; other lanes keep their old value.
- **Read:** the RAM word is sampled at the accept edge.
  - A read accepted the cycle after a write to the same word returns the new data.
  - Read data ignores `wb_sel_i`; all 4 bytes are returned.
- **Response pipeline:** each accepted request enters a shift register of `LATENCY` stages carrying {valid, data}.
  - Writes carry data 0.
  - The last stage drives `wb_dat_o`, which is 0 when that stage is not valid.
  - `wb_ack_o` = last-stage valid AND `wb_cyc_i`.
- **Outstanding counter:** `outstanding_q` increments on accept and decrements when the last stage is valid. Both may happen in the same cycle, giving a net of 0.
- **Stall:** `wb_stall_o` = (`outstanding_q` == FIFO_DEPTH). It is driven from the register only and has no combinational path from inputs.
- **Ordering:** responses return strictly in acceptance order.
- **Abort:** if `wb_cyc_i` is low at a rising edge:
  - all pipeline valid bits and `outstanding_q` clear at that edge;
  - no ack is produced for flushed requests;
  - writes already committed remain in memory.
- **Idle strobe:** `wb_stb_i` high with `wb_cyc_i` low is never accepted.
- **Reset:** `rst_ni` low asynchronously clears:
  - all valid bits and `outstanding_q`;
  - `wb_ack_o` = 0, `wb_stall_o` = 0, `wb_dat_o` = 0.

  RAM contents are not reset.

## Timing
- **Latency:** request accepted in cycle t gets `wb_ack_o`=1 in cycle t+LATENCY, for exactly one cycle.
- **Throughput:** one request per cycle is sustained when FIFO_DEPTH >= LATENCY+1. Otherwise the stall pattern follows from the counter rule.
- **Stall timing:** `wb_stall_o` rises the cycle after the accept that fills the counter. It falls the cycle after the edge where an ack drains it, when no accept occurs at that edge.
- **Reset deassertion:** `rst_ni` rising; the first accept is possible in the first clock cycle with `rst_ni`=1.
- **Abort timing:** `wb_cyc_i` dropped in cycle t:
  - `wb_ack_o`=0 in cycle t (gated);
  - `wb_stall_o`=0 in cycle t+1.

## Test plan
- **Reset mid-stream:**
  - Stimulus: drive `rst_ni` low between clock edges while 2 reads are in flight.
  - Required response: `wb_ack_o`, `wb_stall_o`, `wb_dat_o` go to 0 immediately. No ack follows after release.
- **Write/read (LATENCY=1):**
  - Stimulus: write 0xDEADBEEF, sel 0xF, to 0x10; next cycle read 0x10.
  - Required response: write acked at t+1; read acked at t+2 with `wb_dat_o`=0xDEADBEEF.
- **Byte select:**
  - Stimulus: over 0xDEADBEEF at 0x10, write 0x11223344 with sel 0b0101, then read 0x10.
  - Required response: 0xDE22BE44. A read of 0x1010 with ADDR_WIDTH=10 (word 0x404, which aliases to word 0x4) also returns 0xDE22BE44.
- **Back-to-back reads (LATENCY=1, FIFO_DEPTH=2):**
  - Stimulus: 4 consecutive reads of words 0..3 preloaded 0xA0..0xA3.
  - Required response: `wb_stall_o` never asserts; acks in 4 consecutive cycles carry 0xA0, 0xA1, 0xA2, 0xA3.
- **Back-pressure (LATENCY=3, FIFO_DEPTH=2):**
  - Stimulus: strobe reads continuously from t0.
  - Required response:
    - accepts at t0 and t1;
    - stall high in t2–t3;
    - acks at t3 and t4;
    - third request accepted at t4 and acked at t7.
- **Abort:**
  - Stimulus: 2 reads in flight (LATENCY=3); drop `wb_cyc_i` for 1 cycle.
  - Required response: no acks for them; `outstanding_q`=0. A subsequent read of 0x10 is acked after 3 cycles with the correct data.

Source files
------------

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 slave over a word-organised RAM: fixed-latency responses,
// bounded outstanding requests, back-pressure via registered stall.
module wb_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o
);
  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  logic [31:0]               mem [WORDS];
  logic [LATENCY-1:0]        vld_pipe;
  logic [LATENCY-1:0][31:0]  dat_pipe;
  logic [CW-1:0]             outstanding_q;
  logic [ADDR_WIDTH-1:0]     word;
  logic                      accept;
  logic                      last_vld;
  logic                      unused_adr;

  // Byte offset and high address bits are don't-care; the RAM aliases.
  assign word       = wb_adr_i[ADDR_WIDTH+1:2];
  assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

  assign wb_stall_o = (outstanding_q == CW'(FIFO_DEPTH));
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign last_vld   = vld_pipe[LATENCY-1];
  assign wb_ack_o   = last_vld & wb_cyc_i;
  assign wb_dat_o   = last_vld ? dat_pipe[LATENCY-1] : '0;

  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[word][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  // Dropping cyc flushes everything in flight; committed writes stay in the RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe      <= '0;
      dat_pipe      <= '0;
      outstanding_q <= '0;
    end else if (!wb_cyc_i) begin
      vld_pipe      <= '0;
      outstanding_q <= '0;
    end else begin
      vld_pipe[0] <= accept;
      dat_pipe[0] <= (accept && !wb_we_i) ? mem[word] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
      outstanding_q <= outstanding_q + CW'(accept) - CW'(last_vld);
    end
  end
endmodule
